// File: rtl/uart_pkg.sv
// Shared UART definitions: default link rate and the receiver state encoding.
package uart_pkg;

  localparam int UART_CLK_FREQ = 10_000_000;
  localparam int UART_BAUDRATE = 115200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Even parity bit: the value that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1 so an idle
// UART line does not look like a start bit when reset is released.
module uart_bit_sync (
  input  logic fpga_clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, start / 8 data MSB first / stop, mid-bit sampled on fpga_clk.
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = UART_CLK_FREQ,
  parameter int BAUDRATE     = UART_BAUDRATE,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUDRATE
) (
  input  logic       fpga_clk,
  input  logic       nrst,
  input  logic       sin,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       busy_rx,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic sin_s;

  rx_state_t        state_reg,     state_next;
  logic [CNT_W-1:0] clk_cnt_reg,   clk_cnt_next;
  logic [2:0]       bit_cnt_reg,   bit_cnt_next;
  logic [7:0]       sr_reg,        sr_next;
  logic [7:0]       dout_reg,      dout_next;
  logic             rx_valid_reg,  rx_valid_next;
  logic             frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_reg,    par_bit_next;
  logic             parity_err_reg, parity_err_next;
`endif

  uart_bit_sync u_sync (
    .fpga_clk (fpga_clk),
    .nrst     (nrst),
    .d        (sin),
    .q        (sin_s)
  );

  always_ff @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      sr_reg         <= '0;
      dout_reg       <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      sr_reg         <= sr_next;
      dout_reg       <= dout_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= par_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    clk_cnt_next    = clk_cnt_reg + 1'b1;
    bit_cnt_next    = bit_cnt_reg;
    sr_next         = sr_reg;
    dout_next       = dout_reg;
    rx_valid_next   = 1'b0;
    frame_err_next  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    par_bit_next    = par_bit_reg;
    parity_err_next = parity_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        clk_cnt_next = '0;
        if (!sin_s) state_next = START;
      end

      // Re-check the line half a bit in so a short glitch is not taken as a frame.
      START: begin
        if (clk_cnt_reg == CNT_HALF) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = sin_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          sr_next      = {sr_reg[6:0], sin_s};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          par_bit_next = sin_s;
          state_next   = STOP;
        end
      end
`endif

      // Stop is sampled mid-bit, leaving half a bit to catch a back-to-back start.
      STOP: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next    = '0;
          dout_next       = sr_reg;
          rx_valid_next   = 1'b1;
          frame_err_next  = ~sin_s;
`ifdef UART_RX_PARITY_EN
          parity_err_next = par_bit_reg ^ even_parity(sr_reg);
`endif
          state_next      = sin_s ? IDLE : BREAK;
        end
      end

      BREAK: begin
        clk_cnt_next = '0;
        if (sin_s) state_next = IDLE;
      end

      default: begin
        clk_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  assign dout      = dout_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign busy_rx   = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial line model pushes expected bytes, a
// monitor pops and compares on every rx_valid. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CPB = 10_000_000 / 115200;

  logic       fpga_clk = 1'b0;
  logic       nrst     = 1'b0;
  logic       sin      = 1'b1;
  logic [7:0] dout;
  logic       rx_valid;
  logic       busy_rx;
  logic       frame_err;
  logic       parity_err;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic rx_valid_prev = 1'b0;
  logic [7:0] last_byte = 8'h00;

  uart_rx dut (
    .fpga_clk   (fpga_clk),
    .nrst       (nrst),
    .sin        (sin),
    .dout       (dout),
    .rx_valid   (rx_valid),
    .busy_rx    (busy_rx),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 fpga_clk = ~fpga_clk;

  initial begin
    #(900_000 * 1ns);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge fpga_clk);
  endtask

  // Line model: sends one frame and records what a correct receiver must report.
  // The line is left at the stop-bit level; callers raise it if needed.
  task automatic send_frame(input logic [7:0] data, input int cpb,
                            input logic stop_bit, input logic par_flip);
    exp_t e;
    e.data = data;
    e.fe   = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.pe   = par_flip;
`else
    e.pe   = 1'b0;
`endif
    sb.push_back(e);
    last_byte = data;
    sin = 1'b0;
    wait_clks(cpb);
    for (int i = 7; i >= 0; i--) begin
      sin = data[i];
      wait_clks(cpb);
    end
`ifdef UART_RX_PARITY_EN
    sin = (^data) ^ par_flip;
    wait_clks(cpb);
`endif
    sin = stop_bit;
    wait_clks(cpb);
  endtask

  always @(negedge fpga_clk) begin
    if (nrst && rx_valid) begin
      vectors++;
      if (rx_valid_prev) begin
        miscompares++;
        $display("FAIL pulse_width: rx_valid high on consecutive cycles, required single cycle");
      end
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: dout=%h, required no strobe", dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dout !== e.data || frame_err !== e.fe || parity_err !== e.pe) begin
          miscompares++;
          $display("FAIL rx_frame: dout=%h fe=%b pe=%b, required dout=%h fe=%b pe=%b",
                   dout, frame_err, parity_err, e.data, e.fe, e.pe);
        end else begin
          $display("rx  dout=%h fe=%b pe=%b ok", dout, frame_err, parity_err);
        end
      end
    end
    rx_valid_prev = rx_valid;
  end

  initial begin
    // 1: reset and idle line
    nrst = 1'b0;
    wait_clks(5);
    nrst = 1'b1;
    wait_clks(2000);
    check("reset_dout", dout, 8'h00);
    check("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("reset_busy", {7'd0, busy_rx}, 8'h00);
    check("reset_frame_err", {7'd0, frame_err}, 8'h00);
    check("reset_parity_err", {7'd0, parity_err}, 8'h00);

    // 2: back-to-back frames at nominal rate
    send_frame(8'hA5, CPB, 1'b1, 1'b0);
    send_frame(8'h5A, CPB, 1'b1, 1'b0);
    wait_clks(200);
    check("b2b_pending", 8'(sb.size()), 8'h00);

    // 3: transmitter running at 88 clocks per bit
    send_frame(8'h3C, 88, 1'b1, 1'b0);
    wait_clks(200);
    check("tx88_pending", 8'(sb.size()), 8'h00);

    // 4: short glitch must not produce a strobe
    sin = 1'b0;
    wait_clks(20);
    sin = 1'b1;
    check("glitch_busy_high", {7'd0, busy_rx}, 8'h01);
    wait_clks(100);
    check("glitch_busy_low", {7'd0, busy_rx}, 8'h00);
    check("glitch_dout_kept", dout, last_byte);

    // 5: stop bit low, line held low (break), then recovery
    send_frame(8'h55, CPB, 1'b0, 1'b0);
    wait_clks(500);
    check("break_busy_high", {7'd0, busy_rx}, 8'h01);
    check("break_pending", 8'(sb.size()), 8'h00);
    check("break_frame_err", {7'd0, frame_err}, 8'h01);
    sin = 1'b1;
    wait_clks(10);
    check("break_busy_low", {7'd0, busy_rx}, 8'h00);
    send_frame(8'h01, CPB, 1'b1, 1'b0);
    wait_clks(200);
    check("fe_cleared", {7'd0, frame_err}, 8'h00);
    check("after_break_pending", 8'(sb.size()), 8'h00);

    // 6: reset in the middle of 8'hFF, frame abandoned, then 8'h81
    sin = 1'b0;
    wait_clks(CPB);
    sin = 1'b1;
    wait_clks(3 * CPB + CPB / 2);
    nrst = 1'b0;
    wait_clks(3);
    nrst = 1'b1;
    wait_clks(1);
    check("midreset_dout", dout, 8'h00);
    check("midreset_busy", {7'd0, busy_rx}, 8'h00);
    wait_clks(12 * CPB);
    send_frame(8'h81, CPB, 1'b1, 1'b0);
    wait_clks(200);
    check("midreset_dout_81", dout, 8'h81);
    check("midreset_pending", 8'(sb.size()), 8'h00);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, CPB, 1'b1, 1'b1);
    wait_clks(200);
    check("bad_parity", {7'd0, parity_err}, 8'h01);
    send_frame(8'h07, CPB, 1'b1, 1'b0);
    wait_clks(200);
    check("good_parity", {7'd0, parity_err}, 8'h00);
`endif

    // Random frames: random data, rate within tolerance, random gaps
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       pf;
      d  = 8'($urandom);
      pf = 1'($urandom_range(0, 3) == 0);
      send_frame(d, $urandom_range(84, 88), 1'b1, pf);
      wait_clks($urandom_range(0, 150));
    end
    wait_clks(300);
    check("random_pending", 8'(sb.size()), 8'h00);
    check("final_busy", {7'd0, busy_rx}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
